alarm_timer_mc: RTL and testbench

Parametrised multi-channel interval timer, the next generation of the single-channel Avalon timer slave in the alarm-clock SoC. It provides N_CH independent down-counters of configurable width behind one 16-bit Avalon-MM slave. Each channel adds one-shot/continuous mode, software start/stop and lossless timeout capture. Per-channel interrupt and timeout-pulse vectors feed the Nios II IRQ input and the seconds/alarm logic.

---
 rtl/alarm_timer_pkg.sv | 16 +
 rtl/alarm_timer_channel.sv | 79 +++++++
 rtl/alarm_timer_mc.sv | 61 ++++++
 tb/tb_alarm_timer_mc.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_timer_pkg.sv
// alarm_timer_pkg: register offsets, bit indices and channel state type shared by the multi-channel timer
package alarm_timer_pkg;
    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD_L = 3'd2;
    localparam logic [2:0] REG_PERIOD_H = 3'd3;
    localparam logic [2:0] REG_SNAP_L   = 3'd4;
    localparam logic [2:0] REG_SNAP_H   = 3'd5;
    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;
    localparam int STS_TO    = 0;
    localparam int STS_RUN   = 1;
    typedef enum logic {ST_IDLE, ST_RUN} ch_state_t;
endpackage

// File: rtl/alarm_timer_channel.sv
// alarm_timer_channel: one down-counter channel with run/idle FSM, period, snapshot, TO/ITO and register read mux
module alarm_timer_channel
    import alarm_timer_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int RESET_PERIOD = 49,
    parameter bit ALWAYS_RUN   = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr,
    input  logic [2:0]  reg_sel,
    input  logic [15:0] writedata,
    output logic [15:0] rdata,
    output logic        irq,
    output logic        timeout_pulse
);
    localparam logic [CNT_W-1:0] RST_P = CNT_W'(RESET_PERIOD);
    ch_state_t state, state_n;
    logic [CNT_W-1:0] cnt, period, snap;
    logic to, ito, cont, force_reload, run, tmo;
    logic wr_status, wr_ctl, wr_pl, wr_ph, wr_snap, start, stop;
    assign wr_status = wr && reg_sel == REG_STATUS;
    assign wr_ctl    = wr && reg_sel == REG_CONTROL;
    assign wr_pl     = wr && reg_sel == REG_PERIOD_L;
    assign wr_ph     = wr && reg_sel == REG_PERIOD_H;
    assign wr_snap   = wr && (reg_sel == REG_SNAP_L || reg_sel == REG_SNAP_H);
    assign start     = wr_ctl && writedata[CTL_START];
    assign stop      = wr_ctl && writedata[CTL_STOP];
    assign run       = state == ST_RUN;
    // a pending period reload suppresses the zero-reload timeout for that cycle
    assign tmo       = run && cnt == '0 && !force_reload;
    assign irq       = to && ito;
    always_comb begin
        state_n = ALWAYS_RUN ? ST_RUN :
                  stop ? ST_IDLE :
                  start ? ST_RUN :
                  (tmo && !cont) ? ST_IDLE : state;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ALWAYS_RUN ? ST_RUN : ST_IDLE;
            cnt           <= RST_P;
            period        <= RST_P;
            snap          <= '0;
            to            <= 1'b0;
            ito           <= 1'b0;
            cont          <= ALWAYS_RUN;
            force_reload  <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_n;
            force_reload  <= wr_pl || wr_ph;
            timeout_pulse <= tmo;
            to            <= tmo || (to && !wr_status);
            if (wr_ctl) begin
                ito  <= writedata[CTL_ITO];
                cont <= ALWAYS_RUN || writedata[CTL_CONT];
            end
            if (wr_pl) period[15:0] <= writedata;
            if (wr_ph) period[CNT_W-1:16] <= writedata[CNT_W-17:0];
            if (wr_snap) snap <= cnt;
            if (force_reload || tmo) cnt <= period;
            else if (run) cnt <= cnt - CNT_W'(1);
        end
    end
    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_STATUS:   rdata[1:0] = {run, to};
            REG_CONTROL:  rdata[1:0] = {cont, ito};
            REG_PERIOD_L: rdata = period[15:0];
            REG_PERIOD_H: rdata[CNT_W-17:0] = period[CNT_W-1:16];
            REG_SNAP_L:   rdata = snap[15:0];
            REG_SNAP_H:   rdata[CNT_W-17:0] = snap[CNT_W-1:16];
            default:      rdata = '0;
        endcase
    end
endmodule

// File: rtl/alarm_timer_mc.sv
// alarm_timer_mc: N_CH interval timer channels behind one 16-bit Avalon-MM slave with registered read data
module alarm_timer_mc
    import alarm_timer_pkg::*;
#(
    parameter int N_CH         = 2,
    parameter int CNT_W        = 32,
    parameter int RESET_PERIOD = 49,
    parameter bit ALWAYS_RUN   = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [2+$clog2(N_CH):0]   address,
    input  logic                      chipselect,
    input  logic                      write_n,
    input  logic [15:0]               writedata,
    output logic [15:0]               readdata,
    output logic                      irq,
    output logic [N_CH-1:0]           irq_ch,
    output logic [N_CH-1:0]           timeout_pulse
);
    localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1;
    logic [CH_W-1:0] ch;
    logic [15:0] rdata [N_CH];
    logic [15:0] rd_mux;
    logic we;
    assign we = chipselect && !write_n;
    generate
        if (N_CH > 1) begin : g_multi
            assign ch = address[2+CH_W:3];
        end else begin : g_single
            assign ch = '0;
        end
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            alarm_timer_channel #(
                .CNT_W(CNT_W),
                .RESET_PERIOD(RESET_PERIOD),
                .ALWAYS_RUN(ALWAYS_RUN)
            ) u_ch (
                .clk(clk),
                .reset_n(reset_n),
                .wr(we && ch == CH_W'(i)),
                .reg_sel(address[2:0]),
                .writedata(writedata),
                .rdata(rdata[i]),
                .irq(irq_ch[i]),
                .timeout_pulse(timeout_pulse[i])
            );
        end
    endgenerate
    // channel indices beyond N_CH (non power-of-two counts) read as 0
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_CH; i++)
            if (ch == CH_W'(i)) rd_mux = rdata[i];
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else readdata <= rd_mux;
    end
    assign irq = |irq_ch;
endmodule

// File: tb/tb_alarm_timer_mc.sv
// tb_alarm_timer_mc: randomized scenario tests against an arithmetic timeout-schedule model
module tb_alarm_timer_mc;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [3:0]  address = '0;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic        irq;
    logic [1:0]  irq_ch, timeout_pulse;
    int cyc = 0, checks = 0, passes = 0;
    int q0[$], q1[$];
    int s1, p1, s0, t_stop;

    alarm_timer_mc dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
        .irq_ch(irq_ch), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (timeout_pulse[0]) q0.push_back(cyc);
        if (timeout_pulse[1]) q1.push_back(cyc);
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // model: counter value c at start edge s, period p -> k-th timeout pulse edge
    function automatic int nth_pulse(input int s, input int c, input int p, input int k);
        return s + c + 1 + k * (p + 1);
    endfunction
    function automatic int n_pulses(input int s, input int c, input int p, input int upto);
        return upto < s + c + 1 ? 0 : (upto - s - c - 1) / (p + 1) + 1;
    endfunction

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic wait_edge(input int e);
        while (cyc < e - 1) step(1);
    endtask
    task automatic wr(input int ch, input int r, input logic [15:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = {ch[0], r[2:0]}; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask
    task automatic rd(input int ch, input int r, output logic [15:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b1; address = {ch[0], r[2:0]};
        @(posedge clk); #1;
        d = readdata; chipselect = 1'b0;
    endtask

    task automatic test_reset;
        logic [15:0] d;
        int bad = 0;
        #1;
        checks++; if (readdata !== 16'h0) $display("FAIL reset_readdata: got %h want 0000", readdata); else passes++;
        step(3);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        rd(0, 0, d); checks++; if (d !== 16'h0000) $display("FAIL reset_status: got %h want 0000", d); else passes++;
        rd(0, 1, d); checks++; if (d !== 16'h0000) $display("FAIL reset_control: got %h want 0000", d); else passes++;
        rd(0, 2, d); checks++; if (d !== 16'h0031) $display("FAIL reset_period_l: got %h want 0031", d); else passes++;
        rd(1, 3, d); checks++; if (d !== 16'h0000) $display("FAIL reset_period_h: got %h want 0000", d); else passes++;
        rd(1, 4, d); checks++; if (d !== 16'h0000) $display("FAIL reset_snap_l: got %h want 0000", d); else passes++;
        repeat (100) begin
            step(1);
            if (irq !== 1'b0 || timeout_pulse !== 2'b00) bad++;
        end
        checks++; if (bad != 0 || q0.size() + q1.size() != 0)
            $display("FAIL reset_quiet: got %0d active cycles want 0", bad + q0.size() + q1.size()); else passes++;
    endtask

    task automatic test_continuous;
        int f;
        p1 = $urandom_range(2, 9);
        wr(1, 2, 16'(p1));
        wr(1, 1, 16'h0007);
        s1 = cyc;
        f = nth_pulse(s1, p1, p1, 0);
        wait_edge(f);
        checks++; if (irq !== 1'b0) $display("FAIL cont_irq_before: got %b want 0", irq); else passes++;
        step(1);
        checks++; if (irq !== 1'b1 || irq_ch !== 2'b10) $display("FAIL cont_irq_first: got irq=%b irq_ch=%b want 1/10", irq, irq_ch); else passes++;
        checks++; if (timeout_pulse !== 2'b10) $display("FAIL cont_pulse_first: got %b want 10", timeout_pulse); else passes++;
        step(4 * (p1 + 1));
        checks++; if (q1.size() != n_pulses(s1, p1, p1, cyc - 1))
            $display("FAIL cont_count: got %0d want %0d", q1.size(), n_pulses(s1, p1, p1, cyc - 1)); else passes++;
        for (int k = 0; k < q1.size(); k++) begin
            checks++; if (q1[k] != nth_pulse(s1, p1, p1, k))
                $display("FAIL cont_edge%0d: got %0d want %0d", k, q1[k], nth_pulse(s1, p1, p1, k)); else passes++;
        end
    endtask

    task automatic test_one_shot;
        logic [15:0] d;
        int p, s;
        p = $urandom_range(2, 6);
        wr(0, 2, 16'(p));
        wr(0, 1, 16'h0004);
        s = cyc;
        wait_edge(s + 4 * p + 8);
        checks++; if (q0.size() != 1) $display("FAIL oneshot_count: got %0d want 1", q0.size()); else passes++;
        if (q0.size() > 0) begin
            checks++; if (q0[0] != s + p + 1) $display("FAIL oneshot_edge: got %0d want %0d", q0[0], s + p + 1); else passes++;
        end
        rd(0, 0, d); checks++; if (d !== 16'h0001) $display("FAIL oneshot_status: got %h want 0001", d); else passes++;
        checks++; if (irq_ch[0] !== 1'b0) $display("FAIL oneshot_irq_masked: got %b want 0", irq_ch[0]); else passes++;
        wr(0, 4, 16'h0);
        rd(0, 4, d); checks++; if (d !== 16'(p)) $display("FAIL oneshot_snap_l: got %h want %h", d, 16'(p)); else passes++;
        rd(0, 5, d); checks++; if (d !== 16'h0) $display("FAIL oneshot_snap_h: got %h want 0000", d); else passes++;
    endtask

    task automatic test_status_race;
        logic [15:0] d;
        int k, x, y;
        k = n_pulses(s1, p1, p1, cyc + 2);
        x = nth_pulse(s1, p1, p1, k);
        y = nth_pulse(s1, p1, p1, k + 1);
        wait_edge(x);
        wr(1, 0, 16'h0);
        rd(1, 0, d); checks++; if (d !== 16'h0003) $display("FAIL race_status: got %h want 0003", d); else passes++;
        wr(1, 0, 16'h0);
        checks++; if (irq !== 1'b0 || irq_ch !== 2'b00) $display("FAIL race_irq_cleared: got irq=%b irq_ch=%b want 0/00", irq, irq_ch); else passes++;
        wait_edge(y);
        step(1);
        checks++; if (irq !== 1'b1 || timeout_pulse[1] !== 1'b1)
            $display("FAIL race_irq_reassert: got irq=%b pulse=%b want 1/1", irq, timeout_pulse[1]); else passes++;
    endtask

    task automatic test_snapshot32;
        logic [15:0] d;
        int dl, e;
        wr(0, 3, 16'h0001);
        wr(0, 2, 16'h0000);
        wr(0, 1, 16'h0004);
        s0 = cyc;
        dl = $urandom_range(2, 40);
        wait_edge(s0 + dl);
        wr(0, 4, 16'h0);
        e = 32'h10000 - (dl - 1);
        rd(0, 4, d); checks++; if (d !== e[15:0]) $display("FAIL snap32_l: got %h want %h", d, e[15:0]); else passes++;
        rd(0, 5, d); checks++; if (d !== e[31:16]) $display("FAIL snap32_h: got %h want %h", d, e[31:16]); else passes++;
        rd(0, 3, d); checks++; if (d !== 16'h0001) $display("FAIL snap32_period_h: got %h want 0001", d); else passes++;
        wr(0, 1, 16'h0008);
        t_stop = cyc;
    endtask

    task automatic test_start_stop;
        logic [15:0] d;
        int e, v, n;
        wr(0, 0, 16'h0);
        wr(0, 1, 16'h000C);
        rd(0, 0, d); checks++; if (d !== 16'h0000) $display("FAIL startstop_status: got %h want 0000", d); else passes++;
        step(7);
        wr(0, 4, 16'h0);
        e = 32'h10000 - (t_stop - s0);
        rd(0, 4, d); checks++; if (d !== e[15:0]) $display("FAIL stop_hold_l: got %h want %h", d, e[15:0]); else passes++;
        rd(0, 5, d); checks++; if (d !== e[31:16]) $display("FAIL stop_hold_h: got %h want %h", d, e[31:16]); else passes++;
        n = q0.size();
        v = $urandom_range(1, 16'hFFFF);
        wr(0, 3, 16'h0);
        wr(0, 2, 16'(v));
        step(2);
        wr(0, 4, 16'h0);
        rd(0, 4, d); checks++; if (d !== 16'(v)) $display("FAIL idle_reload_l: got %h want %h", d, 16'(v)); else passes++;
        rd(0, 5, d); checks++; if (d !== 16'h0) $display("FAIL idle_reload_h: got %h want 0000", d); else passes++;
        rd(0, 0, d); checks++; if (d !== 16'h0000) $display("FAIL idle_reload_status: got %h want 0000", d); else passes++;
        checks++; if (q0.size() != n) $display("FAIL idle_reload_pulse: got %0d pulses want 0", q0.size() - n); else passes++;
    endtask

    task automatic test_back_to_back;
        int p0, s, n;
        p0 = $urandom_range(1, 6);
        wr(0, 2, 16'(p0));
        wr(0, 1, 16'h0007);
        s = cyc;
        step(6 * (p0 + 1) + 4);
        n = n_pulses(s, p0, p0, cyc - 1);
        checks++; if (q0.size() != n + 1) $display("FAIL b2b_count: got %0d want %0d", q0.size(), n + 1); else passes++;
        for (int k = 1; k < q0.size(); k++) begin
            checks++; if (q0[k] != nth_pulse(s, p0, p0, k - 1))
                $display("FAIL b2b_edge%0d: got %0d want %0d", k, q0[k], nth_pulse(s, p0, p0, k - 1)); else passes++;
        end
        checks++; if (irq_ch !== 2'b11 || irq !== 1'b1) $display("FAIL b2b_irq: got irq=%b irq_ch=%b want 1/11", irq, irq_ch); else passes++;
        checks++; if (q1.size() != n_pulses(s1, p1, p1, cyc - 1))
            $display("FAIL ch1_total_count: got %0d want %0d", q1.size(), n_pulses(s1, p1, p1, cyc - 1)); else passes++;
        for (int k = 0; k < q1.size(); k++) begin
            checks++; if (q1[k] != nth_pulse(s1, p1, p1, k))
                $display("FAIL ch1_total_edge%0d: got %0d want %0d", k, q1[k], nth_pulse(s1, p1, p1, k)); else passes++;
        end
    endtask

    task automatic test_async_reset;
        logic [15:0] d;
        int n;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (timeout_pulse !== 2'b00 || irq !== 1'b0 || readdata !== 16'h0)
            $display("FAIL async_reset_outputs: got pulse=%b irq=%b rd=%h want 00/0/0000", timeout_pulse, irq, readdata); else passes++;
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        n = q0.size() + q1.size();
        step(40);
        checks++; if (q0.size() + q1.size() != n) $display("FAIL async_reset_idle: got %0d pulses want 0", q0.size() + q1.size() - n); else passes++;
        rd(1, 0, d); checks++; if (d !== 16'h0000) $display("FAIL async_reset_status: got %h want 0000", d); else passes++;
        rd(1, 2, d); checks++; if (d !== 16'h0031) $display("FAIL async_reset_period: got %h want 0031", d); else passes++;
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_one_shot();
        test_status_race();
        test_snapshot32();
        test_start_stop();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
